// File: rtl/mem_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_pkg
// Description : Size encodings, controller FSM states and byte-count helper.
//               ST_SPLIT exists only when MISALIGNED_SPLIT_EN is defined.
// Revision    : 1.0
// ============================================================================
package mem_pkg;

   localparam logic [1:0] SZ_BYTE    = 2'b00;
   localparam logic [1:0] SZ_HALF    = 2'b01;
   localparam logic [1:0] SZ_WORD    = 2'b10;
   localparam logic [1:0] SZ_ILLEGAL = 2'b11;

   localparam logic [1:0] ST_IDLE    = 2'd0;
   localparam logic [1:0] ST_ACCESS  = 2'd1;
   localparam logic [1:0] ST_RESP    = 2'd2;
`ifdef MISALIGNED_SPLIT_EN
   localparam logic [1:0] ST_SPLIT   = 2'd3;
`endif

   // Illegal size reports zero bytes; callers reject it before using the count.
   function automatic logic [2:0] byte_count(input logic [1:0] size);
      logic [2:0] n;
      case (size)
         SZ_BYTE: n = 3'd1;
         SZ_HALF: n = 3'd2;
         SZ_WORD: n = 3'd4;
         default: n = 3'd0;
      endcase
      return n;
   endfunction

endpackage
`default_nettype wire

// File: rtl/load_extend.sv
`default_nettype none
// ============================================================================
// Module      : load_extend
// Description : Combinational load-data extension; only the low byte/halfword
//               lanes of raw are used so any upstream extension is discarded.
// Revision    : 1.0
// ============================================================================
module load_extend
   import mem_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic [1:0]         size,
   input  logic               unsigned_ld,
   input  logic [4*WIDTH-1:0] raw,
   output logic [4*WIDTH-1:0] ext
);

   logic w_sign_b;
   logic w_sign_h;

   assign w_sign_b = ~unsigned_ld & raw[WIDTH-1];
   assign w_sign_h = ~unsigned_ld & raw[2*WIDTH-1];

   always_comb begin
      ext = '0;
      case (size)
         SZ_BYTE: ext = {{(3*WIDTH){w_sign_b}}, raw[WIDTH-1:0]};
         SZ_HALF: ext = {{(2*WIDTH){w_sign_h}}, raw[2*WIDTH-1:0]};
         SZ_WORD: ext = raw;
         default: ext = '0;
      endcase
   end

endmodule
`default_nettype wire

// File: rtl/mem_access_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : mem_access_ctrl
// Description : CPU load/store controller for a byte-addressed data memory.
//               Define MISALIGNED_SPLIT_EN to split misaligned accesses into
//               byte beats; otherwise misaligned requests are rejected.
// Revision    : 1.0
// ============================================================================
module mem_access_ctrl
   import mem_pkg::*;
#(
   parameter int MEM_DEPTH = 1024,
   parameter int WIDTH     = 8
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               req_valid,
   output logic               req_ready,
   input  logic               req_we,
   input  logic [1:0]         req_size,
   input  logic               req_unsigned,
   input  logic [4*WIDTH-1:0] req_addr,
   input  logic [4*WIDTH-1:0] req_wdata,
   output logic               resp_valid,
   input  logic               resp_ready,
   output logic [4*WIDTH-1:0] resp_rdata,
   output logic               resp_err,
   output logic               mem_wr_en,
   output logic [1:0]         mem_data_size,
   output logic [4*WIDTH-1:0] mem_addr,
   output logic [4*WIDTH-1:0] mem_wr_data,
   input  logic [4*WIDTH-1:0] mem_rd_data
);

   localparam int                c_BUS   = 4 * WIDTH;
   localparam logic [c_BUS-1:0]  c_DEPTH = c_BUS'(MEM_DEPTH);

   logic [1:0]       r_state;
   logic             r_we;
   logic [1:0]       r_size;
   logic             r_unsigned;

   logic [2:0]       w_bytes;
   logic [c_BUS:0]   w_end;
   logic             w_range_err;
   logic             w_misaligned;
   logic             w_err;
   logic             w_accept;
   logic [c_BUS-1:0] w_raw;
   logic [c_BUS-1:0] w_ext;

   assign req_ready = (r_state == ST_IDLE);
   assign w_accept  = req_valid & req_ready;

   // One extra bit catches a wrap past the top of the address space.
   assign w_bytes     = byte_count(req_size);
   assign w_end       = {1'b0, req_addr} + (c_BUS+1)'(w_bytes) - (c_BUS+1)'(1);
   assign w_range_err = w_end[c_BUS] | (w_end[c_BUS-1:0] >= c_DEPTH);

   assign w_misaligned = ((req_size == SZ_HALF) & req_addr[0]) |
                         ((req_size == SZ_WORD) & (|req_addr[1:0]));

`ifdef MISALIGNED_SPLIT_EN
   logic [c_BUS-1:0] r_addr;
   logic [c_BUS-1:0] r_wdata;
   logic [c_BUS-1:0] r_asm;
   logic [1:0]       r_beat;
   logic [1:0]       r_last;
   logic [1:0]       w_next_beat;
   logic [c_BUS-1:0] w_asm;
   logic [c_BUS-1:0] w_wshift;
   logic [WIDTH-1:0] w_wbyte;

   assign w_err       = (req_size == SZ_ILLEGAL) | w_range_err;
   assign w_next_beat = r_beat + 2'd1;
   assign w_asm       = r_asm |
                        ({{(c_BUS-WIDTH){1'b0}}, mem_rd_data[WIDTH-1:0]} << (WIDTH * int'(r_beat)));
   assign w_wshift    = r_wdata >> (WIDTH * int'(w_next_beat));
   assign w_wbyte     = w_wshift[WIDTH-1:0];
   assign w_raw       = (r_state == ST_SPLIT) ? w_asm : mem_rd_data;
`else
   assign w_err = (req_size == SZ_ILLEGAL) | w_range_err | w_misaligned;
   assign w_raw = mem_rd_data;
`endif

   load_extend #(
      .WIDTH       (WIDTH)
   ) u_load_extend (
      .size        (r_size),
      .unsigned_ld (r_unsigned),
      .raw         (w_raw),
      .ext         (w_ext)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state       <= ST_IDLE;
         r_we          <= 1'b0;
         r_size        <= SZ_BYTE;
         r_unsigned    <= 1'b0;
         resp_valid    <= 1'b0;
         resp_err      <= 1'b0;
         resp_rdata    <= '0;
         mem_wr_en     <= 1'b0;
         mem_data_size <= SZ_BYTE;
         mem_addr      <= '0;
         mem_wr_data   <= '0;
`ifdef MISALIGNED_SPLIT_EN
         r_addr        <= '0;
         r_wdata       <= '0;
         r_asm         <= '0;
         r_beat        <= 2'd0;
         r_last        <= 2'd0;
`endif
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (w_accept) begin
                  r_we       <= req_we;
                  r_size     <= req_size;
                  r_unsigned <= req_unsigned;
                  if (w_err) begin
                     r_state    <= ST_RESP;
                     resp_valid <= 1'b1;
                     resp_err   <= 1'b1;
                     resp_rdata <= '0;
                  end
`ifdef MISALIGNED_SPLIT_EN
                  else if (w_misaligned) begin
                     r_state       <= ST_SPLIT;
                     r_addr        <= req_addr;
                     r_wdata       <= req_wdata;
                     r_asm         <= '0;
                     r_beat        <= 2'd0;
                     r_last        <= 2'(w_bytes - 3'd1);
                     mem_addr      <= req_addr;
                     mem_data_size <= SZ_BYTE;
                     mem_wr_en     <= req_we;
                     mem_wr_data   <= {{(c_BUS-WIDTH){1'b0}}, req_wdata[WIDTH-1:0]};
                  end
`endif
                  else begin
                     r_state       <= ST_ACCESS;
                     mem_addr      <= req_addr;
                     mem_data_size <= req_size;
                     mem_wr_en     <= req_we;
                     mem_wr_data   <= req_wdata;
                  end
               end
            end

            ST_ACCESS: begin
               mem_wr_en  <= 1'b0;
               resp_valid <= 1'b1;
               resp_err   <= 1'b0;
               resp_rdata <= r_we ? '0 : w_ext;
               r_state    <= ST_RESP;
            end

`ifdef MISALIGNED_SPLIT_EN
            ST_SPLIT: begin
               r_asm <= w_asm;
               if (r_beat == r_last) begin
                  mem_wr_en  <= 1'b0;
                  resp_valid <= 1'b1;
                  resp_err   <= 1'b0;
                  resp_rdata <= r_we ? '0 : w_ext;
                  r_state    <= ST_RESP;
               end else begin
                  r_beat      <= w_next_beat;
                  mem_addr    <= r_addr + c_BUS'(w_next_beat);
                  mem_wr_data <= {{(c_BUS-WIDTH){1'b0}}, w_wbyte};
                  mem_wr_en   <= r_we;
               end
            end
`endif

            ST_RESP: begin
               if (resp_ready) begin
                  resp_valid <= 1'b0;
                  resp_err   <= 1'b0;
                  resp_rdata <= '0;
                  r_state    <= ST_IDLE;
               end
            end

            default: begin
               mem_wr_en <= 1'b0;
               r_state   <= ST_IDLE;
            end
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_mem_access_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_access_ctrl
// Description : Directed table-driven bench for mem_access_ctrl with a
//               byte-array memory model (honours MISALIGNED_SPLIT_EN).
// Revision    : 1.0
// ============================================================================
module tb_mem_access_ctrl;

`ifdef MISALIGNED_SPLIT_EN
   localparam bit SPLIT = 1'b1;
`else
   localparam bit SPLIT = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic        req_we = 1'b0;
   logic [1:0]  req_size = 2'b00;
   logic        req_unsigned = 1'b0;
   logic [31:0] req_addr = '0;
   logic [31:0] req_wdata = '0;
   logic        resp_valid;
   logic        resp_ready = 1'b0;
   logic [31:0] resp_rdata;
   logic        resp_err;
   logic        mem_wr_en;
   logic [1:0]  mem_data_size;
   logic [31:0] mem_addr;
   logic [31:0] mem_wr_data;
   logic [31:0] mem_rd_data;

   mem_access_ctrl #(.MEM_DEPTH(1024), .WIDTH(8)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .req_valid     (req_valid),
      .req_ready     (req_ready),
      .req_we        (req_we),
      .req_size      (req_size),
      .req_unsigned  (req_unsigned),
      .req_addr      (req_addr),
      .req_wdata     (req_wdata),
      .resp_valid    (resp_valid),
      .resp_ready    (resp_ready),
      .resp_rdata    (resp_rdata),
      .resp_err      (resp_err),
      .mem_wr_en     (mem_wr_en),
      .mem_data_size (mem_data_size),
      .mem_addr      (mem_addr),
      .mem_wr_data   (mem_wr_data),
      .mem_rd_data   (mem_rd_data)
   );

   always #5 clk = ~clk;

   // Memory model: sign-extends its own reads so the controller must re-extend.
   logic [7:0]  mem [0:1023];
   logic        mem_clr = 1'b1;
   int          wr_cnt = 0;
   logic [31:0] log_addr [0:15];
   logic [9:0]  ma;

   assign ma = mem_addr[9:0];

   always_comb begin
      mem_rd_data = '0;
      case (mem_data_size)
         2'b00:   mem_rd_data = {{24{mem[ma][7]}}, mem[ma]};
         2'b01:   mem_rd_data = {{16{mem[ma+10'd1][7]}}, mem[ma+10'd1], mem[ma]};
         default: mem_rd_data = {mem[ma+10'd3], mem[ma+10'd2], mem[ma+10'd1], mem[ma]};
      endcase
   end

   always @(posedge clk) begin
      if (mem_clr) begin
         for (int i = 0; i < 1024; i++) mem[i] = 8'h00;
      end else if (mem_wr_en) begin
         mem[ma] = mem_wr_data[7:0];
         if (mem_data_size != 2'b00) mem[ma+10'd1] = mem_wr_data[15:8];
         if (mem_data_size == 2'b10) begin
            mem[ma+10'd2] = mem_wr_data[23:16];
            mem[ma+10'd3] = mem_wr_data[31:24];
         end
         log_addr[wr_cnt % 16] = mem_addr;
         wr_cnt = wr_cnt + 1;
      end
   end

   int n_pass = 0;
   int n_tot  = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_tot++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
   endtask

   task automatic run_req(input logic we, input logic [1:0] sz, input logic un,
                          input logic [31:0] a, input logic [31:0] wd,
                          output logic e, output logic [31:0] rd,
                          output int lat, output int nw);
      int w0;
      int guard;
      guard = 0;
      while (!req_ready && guard < 20) begin
         @(posedge clk); #1;
         guard++;
      end
      w0 = wr_cnt;
      req_valid = 1'b1; req_we = we; req_size = sz; req_unsigned = un;
      req_addr = a; req_wdata = wd;
      @(posedge clk); #1;
      req_valid = 1'b0;
      lat = 1;
      while (!resp_valid && lat < 20) begin
         @(posedge clk); #1;
         lat++;
      end
      e  = resp_err;
      rd = resp_rdata;
      resp_ready = 1'b1;
      @(posedge clk); #1;
      resp_ready = 1'b0;
      nw = wr_cnt - w0;
   endtask

   typedef struct {
      logic        we;
      logic [1:0]  size;
      logic        uns;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic        err;
      logic [31:0] rdata;
      int          lat;
      int          writes;
   } vec_t;

   vec_t vecs [0:19];

   initial begin
      logic        e;
      logic [31:0] rd;
      int          lat;
      int          nw;
      int          w0;
      int          k;

      //         we    sz     un    addr           wdata          err               rdata                          lat                writes
      vecs[0]  = '{1'b1, 2'b10, 1'b0, 32'h0000_0010, 32'hDEAD_BEEF, 1'b0,             32'h0,                         2,                 1};
      vecs[1]  = '{1'b0, 2'b10, 1'b0, 32'h0000_0010, 32'h0,         1'b0,             32'hDEAD_BEEF,                 2,                 0};
      vecs[2]  = '{1'b1, 2'b00, 1'b0, 32'h0000_0005, 32'h1234_5680, 1'b0,             32'h0,                         2,                 1};
      vecs[3]  = '{1'b0, 2'b00, 1'b0, 32'h0000_0005, 32'h0,         1'b0,             32'hFFFF_FF80,                 2,                 0};
      vecs[4]  = '{1'b0, 2'b00, 1'b1, 32'h0000_0005, 32'h0,         1'b0,             32'h0000_0080,                 2,                 0};
      vecs[5]  = '{1'b0, 2'b01, 1'b0, 32'h0000_0010, 32'h0,         1'b0,             32'hFFFF_BEEF,                 2,                 0};
      vecs[6]  = '{1'b0, 2'b01, 1'b1, 32'h0000_0012, 32'h0,         1'b0,             32'h0000_DEAD,                 2,                 0};
      vecs[7]  = '{1'b1, 2'b01, 1'b0, 32'h0000_0021, 32'h0000_A5C3, !SPLIT,           32'h0,                         SPLIT ? 3 : 1,     SPLIT ? 2 : 0};
      vecs[8]  = '{1'b0, 2'b01, 1'b1, 32'h0000_0021, 32'h0,         !SPLIT,           SPLIT ? 32'h0000_A5C3 : 32'h0, SPLIT ? 3 : 1,     0};
      vecs[9]  = '{1'b0, 2'b10, 1'b0, 32'h0000_03FE, 32'h0,         1'b1,             32'h0,                         1,                 0};
      vecs[10] = '{1'b1, 2'b10, 1'b0, 32'h0000_03FC, 32'h0BAD_F00D, 1'b0,             32'h0,                         2,                 1};
      vecs[11] = '{1'b0, 2'b10, 1'b0, 32'h0000_03FC, 32'h0,         1'b0,             32'h0BAD_F00D,                 2,                 0};
      vecs[12] = '{1'b0, 2'b10, 1'b0, 32'h0000_0400, 32'h0,         1'b1,             32'h0,                         1,                 0};
      vecs[13] = '{1'b0, 2'b11, 1'b0, 32'h0000_0000, 32'h0,         1'b1,             32'h0,                         1,                 0};
      vecs[14] = '{1'b1, 2'b11, 1'b0, 32'h0000_0010, 32'hFFFF_FFFF, 1'b1,             32'h0,                         1,                 0};
      vecs[15] = '{1'b0, 2'b01, 1'b0, 32'hFFFF_FFFF, 32'h0,         1'b1,             32'h0,                         1,                 0};
      vecs[16] = '{1'b1, 2'b10, 1'b0, 32'h0000_0031, 32'h1122_3344, !SPLIT,           32'h0,                         SPLIT ? 5 : 1,     SPLIT ? 4 : 0};
      vecs[17] = '{1'b0, 2'b10, 1'b0, 32'h0000_0031, 32'h0,         !SPLIT,           SPLIT ? 32'h1122_3344 : 32'h0, SPLIT ? 5 : 1,     0};
      vecs[18] = '{1'b0, 2'b00, 1'b1, 32'h0000_03FF, 32'h0,         1'b0,             32'h0000_000B,                 2,                 0};
      vecs[19] = '{1'b0, 2'b01, 1'b0, 32'h0000_03FC, 32'h0,         1'b0,             32'hFFFF_F00D,                 2,                 0};

      // Reset state
      repeat (3) @(posedge clk);
      #1;
      chk("rst_resp_valid", 32'(resp_valid), 32'h0);
      chk("rst_resp_err", 32'(resp_err), 32'h0);
      chk("rst_resp_rdata", resp_rdata, 32'h0);
      chk("rst_mem_wr_en", 32'(mem_wr_en), 32'h0);
      chk("rst_mem_size", 32'(mem_data_size), 32'h0);
      chk("rst_mem_addr", mem_addr, 32'h0);
      chk("rst_mem_wdata", mem_wr_data, 32'h0);
      chk("rst_req_ready", 32'(req_ready), 32'h1);
      mem_clr = 1'b0;
      rst_n = 1'b1;
      @(posedge clk); #1;

      for (int i = 0; i < 20; i++) begin
         run_req(vecs[i].we, vecs[i].size, vecs[i].uns, vecs[i].addr, vecs[i].wdata, e, rd, lat, nw);
         chk($sformatf("v%0d_err", i), 32'(e), 32'(vecs[i].err));
         chk($sformatf("v%0d_rdata", i), rd, vecs[i].rdata);
         chk($sformatf("v%0d_latency", i), 32'(lat), 32'(vecs[i].lat));
         chk($sformatf("v%0d_writes", i), 32'(nw), 32'(vecs[i].writes));
      end

      // Split store beat order and byte lanes
      w0 = wr_cnt;
      run_req(1'b1, 2'b01, 1'b0, 32'h0000_0041, 32'h0000_5A3C, e, rd, lat, nw);
      chk("half41_err", 32'(e), 32'(!SPLIT));
      chk("half41_mem41", 32'(mem[10'h041]), SPLIT ? 32'h3C : 32'h0);
      chk("half41_mem42", 32'(mem[10'h042]), SPLIT ? 32'h5A : 32'h0);
`ifdef MISALIGNED_SPLIT_EN
      chk("half41_beat0_addr", log_addr[w0 % 16], 32'h41);
      chk("half41_beat1_addr", log_addr[(w0 + 1) % 16], 32'h42);
`endif

      // Response backpressure: held stable, no new request accepted
      req_valid = 1'b1; req_we = 1'b0; req_size = 2'b10; req_unsigned = 1'b0;
      req_addr = 32'h10; req_wdata = '0;
      @(posedge clk); #1;
      req_we = 1'b1;   // now looks like a store that must not be taken
      k = 0;
      while (!resp_valid && k < 20) begin
         @(posedge clk); #1;
         k++;
      end
      w0 = wr_cnt;
      for (int c = 0; c < 3; c++) begin
         chk($sformatf("bp%0d_valid", c), 32'(resp_valid), 32'h1);
         chk($sformatf("bp%0d_rdata", c), resp_rdata, 32'hDEAD_BEEF);
         chk($sformatf("bp%0d_req_ready", c), 32'(req_ready), 32'h0);
         @(posedge clk); #1;
      end
      req_valid = 1'b0;
      resp_ready = 1'b1;
      @(posedge clk); #1;
      resp_ready = 1'b0;
      chk("bp_release_valid", 32'(resp_valid), 32'h0);
      chk("bp_release_ready", 32'(req_ready), 32'h1);
      chk("bp_no_write", 32'(wr_cnt - w0), 32'h0);

      // Reset in the middle of a transaction
      w0 = wr_cnt;
`ifdef MISALIGNED_SPLIT_EN
      req_valid = 1'b1; req_we = 1'b1; req_size = 2'b10; req_unsigned = 1'b0;
      req_addr = 32'h01; req_wdata = 32'hA1B2_C3D4;
      @(posedge clk); #1;
      req_valid = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b0;
      #1;
      chk("mr_resp_valid", 32'(resp_valid), 32'h0);
      chk("mr_mem_wr_en", 32'(mem_wr_en), 32'h0);
      chk("mr_mem_addr", mem_addr, 32'h0);
      chk("mr_mem_wdata", mem_wr_data, 32'h0);
      chk("mr_req_ready", 32'(req_ready), 32'h1);
      repeat (2) @(posedge clk);
      #1;
      chk("mr_mem01", 32'(mem[10'h001]), 32'hD4);
      chk("mr_mem02", 32'(mem[10'h002]), 32'h00);
      chk("mr_writes", 32'(wr_cnt - w0), 32'h1);
      rst_n = 1'b1;
      @(posedge clk); #1;
      run_req(1'b0, 2'b00, 1'b0, 32'h01, 32'h0, e, rd, lat, nw);
      chk("mr_reload", rd, 32'hFFFF_FFD4);
`else
      req_valid = 1'b1; req_we = 1'b1; req_size = 2'b10; req_unsigned = 1'b0;
      req_addr = 32'h08; req_wdata = 32'hCAFE_F00D;
      @(posedge clk); #1;
      req_valid = 1'b0;
      rst_n = 1'b0;
      #1;
      chk("mr_resp_valid", 32'(resp_valid), 32'h0);
      chk("mr_mem_wr_en", 32'(mem_wr_en), 32'h0);
      chk("mr_mem_addr", mem_addr, 32'h0);
      chk("mr_req_ready", 32'(req_ready), 32'h1);
      repeat (2) @(posedge clk);
      #1;
      chk("mr_mem08", 32'(mem[10'h008]), 32'h00);
      chk("mr_writes", 32'(wr_cnt - w0), 32'h0);
      rst_n = 1'b1;
      @(posedge clk); #1;
      run_req(1'b0, 2'b10, 1'b0, 32'h08, 32'h0, e, rd, lat, nw);
      chk("mr_reload", rd, 32'h0);
`endif

      $display("%0d/%0d checks passed", n_pass, n_tot);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL global_timeout: simulation did not finish, got timeout expected completion");
      $fatal(1, "timeout");
   end

endmodule
`default_nettype wire

// File: doc/mem_access_ctrl.md
MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

Interface
REQ-001 SHALL have parameter MEM_DEPTH, default 1024: number of addressable bytes in the data memory.
REQ-002 SHALL have parameter WIDTH, default 8: byte width; data and address buses are 4*WIDTH bits.
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 rst_n  in  1  reset, asynchronous, active-low.
REQ-005 req_valid  in  1  CPU request valid.
REQ-006 req_ready  out  1  controller can accept a request.
REQ-007 req_we  in  1  1=store, 0=load.
REQ-008 req_size  in  2  00 byte, 01 halfword, 10 word, 11 illegal.
REQ-009 req_unsigned  in  1  load zero-extends when 1, sign-extends when 0.
REQ-010 req_addr  in  32  byte address.
REQ-011 req_wdata  in  32  store data, right-aligned.
REQ-012 resp_valid  out  1  response valid.
REQ-013 resp_ready  in  1  CPU accepts the response.
REQ-014 resp_rdata  out  32  load result, extended; 0 for stores and errors.
REQ-015 resp_err  out  1  request rejected; no memory write performed.
REQ-016 mem_wr_en  out  1  data memory write strobe, one cycle per write beat.
REQ-017 mem_data_size  out  2  data memory access size, same encoding as req_size.
REQ-018 mem_addr  out  32  data memory byte address.
REQ-019 mem_wr_data  out  32  data memory write data, right-aligned.
REQ-020 mem_rd_data  in  32  data memory combinational read data, valid in the same cycle as mem_addr/mem_data_size.

Function
REQ-021 SHALL implement the FSM IDLE -> ACCESS -> RESP -> IDLE for aligned requests, and IDLE -> SPLIT -> RESP -> IDLE for split requests.
REQ-022 req_ready SHALL be 1 only in IDLE; a request is accepted on the edge where req_valid && req_ready.
REQ-023 Aligned means: halfword addr[0]=0, word addr[1:0]=0; a byte is always aligned.
REQ-024 ACCESS SHALL last one cycle, drive mem_addr and mem_data_size from the request, pulse mem_wr_en if a store, and capture mem_rd_data if a load.
REQ-025 Aligned latency: request accepted at edge N, resp_valid SHALL be 1 from edge N+2.
REQ-026 RESP SHALL hold resp_valid, resp_rdata and resp_err stable until resp_valid && resp_ready, then return to IDLE; no new request is accepted in RESP.
REQ-027 Load extension: byte/halfword extended from bit 7/15 per req_unsigned; word is passed unchanged; the memory's own extension SHALL be ignored.
REQ-028 Error (resp_err=1, no mem_wr_en pulse, resp_rdata=0): req_size=11, or addr+bytes-1 >= MEM_DEPTH, or misaligned with the split feature absent; IDLE -> RESP directly, resp_valid at N+1.
REQ-029 Address arithmetic is 32-bit; a wrap past 0xFFFFFFFF SHALL be treated as out of range.
REQ-030 mem_wr_en SHALL be 0 in every state except ACCESS or SPLIT store beats.

Reset
REQ-031 rst_n low SHALL force IDLE and clear all registered outputs to 0 (resp_valid, resp_err, resp_rdata, mem_wr_en, mem_data_size, mem_addr, mem_wr_data); req_ready=1 from reset.
REQ-032 Reset mid-operation SHALL abort the transaction: no further beats and no response; bytes already written stay written.

Configuration
REQ-033 With MISALIGNED_SPLIT_EN defined, misaligned halfword/word requests SHALL go to SPLIT and issue 2/4 byte beats (mem_data_size=00) at addr+k, k ascending, one per cycle; stores write req_wdata[8k+7:8k], loads assemble the byte lanes; latency is N+1+beats.
REQ-034 Without MISALIGNED_SPLIT_EN, SPLIT and the beat counter SHALL NOT exist, and misaligned requests SHALL error per REQ-028.

Structure
REQ-035 Package mem_pkg SHALL hold the size encodings (SZ_BYTE, SZ_HALF, SZ_WORD), the FSM state encoding and the byte-count function; the data memory also uses the size encodings.
REQ-036 Sub-module load_extend (size, unsigned, raw 32b -> extended 32b, combinational) SHALL perform load extension.

Verification
REQ-037 Store word 0xDEADBEEF @0x10, then load word @0x10 -> one mem_wr_en pulse, resp_rdata=0xDEADBEEF, resp_valid at N+2.
REQ-038 Memory byte 0x80 @0x05: load byte signed -> 0xFFFFFF80; load byte unsigned -> 0x00000080.
REQ-039 Store half 0xA5C3 @0x21: with macro -> writes 0x21=0xC3 then 0x22=0xA5, resp_err=0; without macro -> resp_err=1, no mem_wr_en.
REQ-040 Load word @0x3FE with MEM_DEPTH=1024 -> resp_err=1, resp_rdata=0; req_size=11 -> resp_err=1.
REQ-041 resp_ready held low 3 cycles -> response held stable and req_ready=0; with macro, store word @0x01 with rst_n low on beat 2 -> only byte 0x01 written, all outputs 0, req_ready=1.
